// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode, FSM state and width definitions for the ALU sharing arbiter
package alu_pkg;
  localparam int WIDTH = 32;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant with a priority pointer updated on completion
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update,
  input  logic       winner,
  output logic [1:0] grant
);
  logic prio;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio <= 1'b0;
    else if (update) prio <= ~winner;
  always_comb
    grant = (valid == 2'b11) ? (prio ? 2'b10 : 2'b01) :
            valid[0] ? 2'b01 : valid[1] ? 2'b10 : 2'b00;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one add/sub ALU between two requesters with round-robin arbitration
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_negative,
  output logic [WIDTH-1:0] alu_data_r1,
  output logic [WIDTH-1:0] alu_data_r2,
  output logic             alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  output logic             busy
);
  state_t           state;
  logic             owner;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic [1:0]       grant;
  logic             hs;
  logic             rsp_hs;
  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (req_valid),
    .update (rsp_hs),
    .winner (owner),
    .grant  (grant)
  );
  // rst_n gates req_ready so every output reads 0 while reset is held
  always_comb begin
    req_ready   = (rst_n && state == S_IDLE) ? grant : 2'b00;
    hs          = |(req_valid & req_ready);
    rsp_valid   = (state == S_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    rsp_hs      = |(rsp_valid & rsp_ready);
    busy        = state != S_IDLE;
    alu_data_r1 = (state == S_EXEC) ? op_a : '0;
    alu_data_r2 = (state == S_EXEC) ? op_b : '0;
    alu_control = (state == S_EXEC) ? op_sub : ALU_ADD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      owner        <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_sub       <= ALU_ADD;
      rsp_result   <= '0;
      rsp_negative <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (hs) begin
            op_a   <= grant[1] ? req1_a : req0_a;
            op_b   <= grant[1] ? req1_b : req0_b;
            op_sub <= grant[1] ? req1_sub : req0_sub;
            owner  <= grant[1];
            state  <= S_EXEC;
          end
        S_EXEC: begin
          rsp_result   <= alu_result;
          rsp_negative <= alu_negative;
          state        <= S_RESP;
        end
        S_RESP:
          if (rsp_hs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed self-checking bench with a behavioural ALU behind the arbiter
module tb_alu_share_arbiter;
  import alu_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic [31:0] rsp_result, alu_data_r1, alu_data_r2, alu_result;
  logic        rsp_negative, alu_control, alu_negative, busy;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  assign alu_result   = (alu_control == ALU_SUB) ? alu_data_r1 - alu_data_r2 : alu_data_r1 + alu_data_r2;
  assign alu_negative = alu_result[31];

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_negative(rsp_negative),
    .alu_data_r1(alu_data_r1), .alu_data_r2(alu_data_r2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_negative(alu_negative), .busy(busy)
  );

  task automatic test_reset();
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    @(negedge clk); #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({alu_data_r1, alu_data_r2, alu_control} !== 65'd0) begin failures++; $display("FAIL reset_alu got=%h/%h/%b exp=0", alu_data_r1, alu_data_r2, alu_control); end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || rsp_result !== 32'd0) begin failures++; $display("FAIL reset_release got busy=%b result=%h exp=0/0", busy, rsp_result); end
  endtask

  task automatic test_single_op(input bit idx, input logic [31:0] a, input logic [31:0] b, input bit sub,
                                input logic [31:0] exp_res, input bit exp_neg, input string name);
    logic [1:0] oh;
    oh = idx ? 2'b10 : 2'b01;
    if (idx) begin req1_a = a; req1_b = b; req1_sub = sub; end
    else begin req0_a = a; req0_b = b; req0_sub = sub; end
    req_valid = oh;
    #1;
    checks++; if (req_ready !== oh) begin failures++; $display("FAIL %s req_ready got=%b exp=%b", name, req_ready, oh); end
    @(negedge clk); req_valid = 2'b00; #1;
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b1) begin failures++; $display("FAIL %s exec_state got rsp_valid=%b busy=%b exp=00/1", name, rsp_valid, busy); end
    checks++; if (alu_data_r1 !== a || alu_data_r2 !== b || alu_control !== sub) begin failures++; $display("FAIL %s alu_drive got=%h/%h/%b exp=%h/%h/%b", name, alu_data_r1, alu_data_r2, alu_control, a, b, sub); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== oh) begin failures++; $display("FAIL %s rsp_valid got=%b exp=%b", name, rsp_valid, oh); end
    checks++; if (rsp_result !== exp_res || rsp_negative !== exp_neg) begin failures++; $display("FAIL %s result got=%h/%b exp=%h/%b", name, rsp_result, rsp_negative, exp_res, exp_neg); end
    checks++; if (alu_data_r1 !== 32'd0 || alu_control !== 1'b0) begin failures++; $display("FAIL %s alu_idle_drive got=%h/%b exp=0/0", name, alu_data_r1, alu_control); end
    rsp_ready = oh;
    @(negedge clk); #1;
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL %s return_idle got rsp_valid=%b busy=%b exp=00/0", name, rsp_valid, busy); end
  endtask

  task automatic test_req0();
    test_single_op(1'b0, 32'd10, 32'd5, 1'b0, 32'd15, 1'b0, "req0_add");
  endtask

  task automatic test_req1();
    test_single_op(1'b1, 32'd4, 32'd8, 1'b1, 32'hFFFF_FFFC, 1'b1, "req1_sub_neg");
    test_single_op(1'b1, 32'd15, 32'd14, 1'b1, 32'd1, 1'b0, "req1_sub_pos");
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    req0_a = 32'd1; req0_b = 32'd1; req0_sub = 1'b0;
    req1_a = 32'd9; req1_b = 32'd3; req1_sub = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0] ? 2'b10 : 2'b01;
      #1;
      checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, req_ready, exp_g); end
      @(negedge clk); #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rr_exec_ready_%0d got=%b exp=00", k, req_ready); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== exp_g || rsp_result !== (k[0] ? 32'd6 : 32'd2)) begin failures++; $display("FAIL rr_rsp_%0d got=%b/%h exp=%b/%h", k, rsp_valid, rsp_result, exp_g, k[0] ? 32'd6 : 32'd2); end
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
    end
    #1;
    rsp_ready = 2'b00;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_end_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    req0_a = 32'd100; req0_b = 32'd1; req0_sub = 1'b1;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_accept got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); req_valid = 2'b10;
    for (int k = 0; k < 7; k++) begin
      rsp_ready = (k < 5) ? 2'b00 : 2'b10;
      #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd99 || req_ready !== 2'b00) begin failures++; $display("FAIL bp_hold_%0d got valid=%b result=%h ready=%b exp=01/00000063/00", k, rsp_valid, rsp_result, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk); #1;
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin failures++; $display("FAIL bp_release got valid=%b ready=%b exp=00/10", rsp_valid, req_ready); end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    req1_a = 32'd7; req1_b = 32'd2; req1_sub = 1'b0;
    req_valid = 2'b10;
    @(negedge clk); req_valid = 2'b00; #1;
    checks++; if (alu_data_r1 !== 32'd7 || busy !== 1'b1) begin failures++; $display("FAIL rst_mid_exec got r1=%h busy=%b exp=00000007/1", alu_data_r1, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (alu_data_r1 !== 32'd0 || alu_data_r2 !== 32'd0 || busy !== 1'b0 || rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_mid_async got r1=%h r2=%h busy=%b valid=%b exp=0", alu_data_r1, alu_data_r2, busy, rsp_valid); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL rst_no_rsp_%0d got valid=%b busy=%b exp=00/0", k, rsp_valid, busy); end
    end
    req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_sub = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_prio got=%b exp=01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h8000_0000 || rsp_negative !== 1'b1) begin failures++; $display("FAIL wrap got=%b/%h/%b exp=01/80000000/1", rsp_valid, rsp_result, rsp_negative); end
    rsp_ready = 2'b01;
    @(negedge clk); rsp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_req0();
    test_req1();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
